stream_pack: RTL and testbench
==============================

# stream_pack

Single-clock stream upsizer that packs RATIO consecutive WIDTH-bit words into one WIDTH*RATIO-bit output word with a per-lane strobe. It sits directly downstream of the read port of a CDC FIFO, in the destination clock domain:

- Its input handshake connects to the FIFO's `o_rdata`/`o_rvalid`/`i_rready`.
- Its output feeds wide consumers such as memory writers or wide buses.
- Partial packets are emitted on explicit flush or, optionally, on idle timeout.

## Interface
Parameters:
- WIDTH, 8, input word width, >= 1.
- RATIO, 4, input words per output word, >= 2, power of 2.
- TIMEOUT, 16, idle cycles before auto-flush, >= 1; used only with STREAM_PACK_TIMEOUT_EN.

Ports:
- i_clk  input  1  clock; one clock for all logic.
- i_rst  input  1  reset, synchronous, active-high.
- i_cg  input  1  clock gate; state updates only on edges where i_cg=1.
- i_data  input  WIDTH  input word.
- i_valid  input  1  input word valid.
- o_ready  output  1  input accept; an input transfer is `i_valid && o_ready`.
- i_flush  input  1  request to emit the current partial packet.
- o_data  output  WIDTH*RATIO  packed word; lane k is bits [k*WIDTH +: WIDTH], lane 0 holds the oldest word.
- o_strb  output  RATIO  lane-valid mask; always contiguous from lane 0.
- o_valid  output  1  packet valid.
- i_ready  input  1  packet accept; an output transfer is `o_valid && i_ready && i_cg`.
- o_count  output  $clog2(RATIO)+1  number of lanes currently filled, 0..RATIO.

## Operation
State machine:
- **IDLE**: count=0.
- **FILL**: 0 < count < RATIO.
- **HOLD**: o_valid=1.

`o_ready = i_cg && (state != HOLD || i_ready)`.

IDLE:
- Input transfer → lane0 = i_data, count=1.
  - If i_flush is high in the same cycle, go to HOLD with strb=0001.
  - Otherwise go to FILL.
- i_flush without an input transfer is ignored; empty packets are never emitted.

FILL:
- Input transfer → lane[count] = i_data, count+1.
  - If count+1 == RATIO, go to HOLD with strb all ones.
- Flush (i_flush, or timeout) → HOLD with strb = (1<<count')-1, where count' includes any word accepted in the same cycle.

HOLD:
- o_data, o_strb and o_count are stable until the output transfer.
- Output transfer without an input transfer → IDLE.
- Output transfer with an input transfer → the new word goes to lane0 of the next packet, count=1.
  - Go to FILL, or to HOLD if i_flush is high in the same cycle.
- i_flush in HOLD without an input transfer is ignored.

Lane content and arithmetic:
- Unfilled lanes of o_data are driven 0.
- All lanes clear on leaving HOLD.
- The count increment never exceeds RATIO.
- Lane index is count[$clog2(RATIO)-1:0].

Reset (i_rst=1 at an edge, regardless of i_cg or current state, including mid-FILL and mid-HOLD):
- State → IDLE, discarding any partial or held packet.
- o_valid=0, o_strb=0, o_data=0, o_count=0, timeout counter=0.
- o_ready = i_cg after reset.

## Timing
- Latency: o_valid rises on the edge that accepts the final word (or the flush edge) and is visible the following cycle. There is no combinational path from i_data to o_data.
- Throughput: one input word per cycle sustained while i_ready=1. There is no bubble at packet boundaries.
- Backpressure: o_ready depends combinationally on i_ready in HOLD only.
- Gating: with i_cg=0, no transfer occurs and all registers hold. o_valid remains asserted if already set.

## Configuration
STREAM_PACK_TIMEOUT_EN is a preprocessor macro.

Defined:
- An idle counter clears on entering FILL and on every input transfer.
- It increments on each gated FILL cycle without an input transfer.
- On the edge where the counter equals TIMEOUT-1 and no input transfer occurs, the block flushes to HOLD.
- o_valid therefore rises TIMEOUT cycles after the last accepting edge.

Undefined:
- No counter is built and the TIMEOUT parameter is unused.
- FILL persists until the packet is full or i_flush is asserted.

## Test plan
All scenarios use WIDTH=8, RATIO=4, TIMEOUT=4.
- Reset, then push 0x11,0x22,0x33,0x44 with i_ready=1 → o_valid=1 for one cycle after the 4th accept, o_data=0x44332211, o_strb=4'b1111, o_count=4.
- Push 0xAA,0xBB, then pulse i_flush → o_data=0x0000BBAA, o_strb=4'b0011, o_count=2; pulsing i_flush again in IDLE → o_valid stays 0.
- Full packet held with i_ready=0 for 5 cycles → o_ready=0 and o_data stable throughout; then i_ready=1 with i_valid=1 and i_data=0x55 → the next cycle shows FILL, o_count=1, lane0=0x55.
- Continuous 8-word stream 0x01..0x08 with i_ready=1 → o_ready is 1 on every cycle; packets 0x04030201 then 0x08070605 with no input stall.
- Macro defined: push 0x01, then idle → o_valid rises 4 cycles after the accept edge with o_strb=4'b0001. Macro undefined: the block stays in FILL for 100 cycles with o_count=1.
- Push 3 words, then assert i_rst for one cycle → o_count=0 and o_valid=0; the next word pushed, 0x77, lands in lane0.

Source files
------------

// File: rtl/stream_pack.sv
// stream_pack: packs RATIO WIDTH-bit words into one wide word with lane strobe.
// Optional idle auto-flush: define STREAM_PACK_TIMEOUT_EN.
module stream_pack #(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cg,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_flush,
  output logic [WIDTH*RATIO-1:0]     o_data,
  output logic [RATIO-1:0]           o_strb,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(RATIO):0]     o_count
);

  localparam int LW = $clog2(RATIO);
  localparam int CW = LW + 1;
  localparam int DW = WIDTH * RATIO;

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || WIDTH < 1 || TIMEOUT < 1)
  begin : g_param_check
    $error("stream_pack: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     data_q, data_d;
  logic [CW-1:0]     count_q, count_d;
  logic [RATIO-1:0]  strb_q, strb_d;
  logic              valid_q, valid_d;

  logic [CW-1:0]     cnt_n;
  logic [RATIO-1:0]  mask_n;
  logic [RATIO-1:0]  one_lane;
  logic              xfer_in;
  logic              xfer_out;
  logic              tmo_fire;

  assign one_lane = {{(RATIO-1){1'b0}}, 1'b1};

  // Accept input unless a held packet is not being drained this cycle.
  assign o_ready  = i_cg && (state_q != S_HOLD || i_ready);
  assign xfer_in  = i_valid && o_ready;
  assign xfer_out = valid_q && i_ready && i_cg;
  assign cnt_n    = count_q + {{(CW-1){1'b0}}, xfer_in};

  // Contiguous strobe for the lane count after this cycle's accept.
  always_comb begin
    mask_n = '0;
    for (int k = 0; k < RATIO; k++) begin
      mask_n[k] = (CW'(k) < cnt_n);
    end
  end

`ifdef STREAM_PACK_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_fire = (state_q == S_FILL) && !xfer_in &&
                    (tmo_q == TW'(TIMEOUT - 1));

  // Idle counter: counts gated FILL cycles with no accepted word.
  always_comb begin
    tmo_d = tmo_q;
    if (i_cg) begin
      if (state_q == S_FILL && state_d == S_FILL && !xfer_in) begin
        tmo_d = tmo_q + TW'(1);
      end else begin
        tmo_d = '0;
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Next-state, lane write and strobe computation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    strb_d  = strb_q;
    if (i_cg) begin
      unique case (state_q)
        S_IDLE: begin
          if (xfer_in) begin
            data_d              = '0;
            data_d[WIDTH-1:0]   = i_data;
            count_d             = CW'(1);
            strb_d              = one_lane;
            state_d             = i_flush ? S_HOLD : S_FILL;
          end
        end
        S_FILL: begin
          if (xfer_in) begin
            data_d[int'(count_q[LW-1:0])*WIDTH +: WIDTH] = i_data;
          end
          count_d = cnt_n;
          strb_d  = mask_n;
          if (cnt_n == CW'(RATIO) || i_flush || tmo_fire) begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (xfer_out) begin
            data_d  = '0;
            count_d = '0;
            strb_d  = '0;
            state_d = S_IDLE;
            if (xfer_in) begin
              data_d[WIDTH-1:0] = i_data;
              count_d           = CW'(1);
              strb_d            = one_lane;
              state_d           = i_flush ? S_HOLD : S_FILL;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          data_d  = '0;
          count_d = '0;
          strb_d  = '0;
        end
      endcase
    end
  end

  assign valid_d = (state_d == S_HOLD);

  // State and output registers, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      strb_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      strb_q  <= strb_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_strb  = strb_q;
  assign o_valid = valid_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_stream_pack.sv
// tb_stream_pack: directed and randomized checks of stream_pack.
// Reference model tracks the packet as a queue of words.
module tb_stream_pack;

  localparam int W = 8;
  localparam int R = 4;
  localparam int T = 4;
`ifdef STREAM_PACK_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cg, vld, fl, rdy;
  logic [7:0]  din;
  logic        ordy, oval;
  logic [31:0] odata;
  logic [3:0]  ostrb;
  logic [2:0]  ocnt;

  always #5 clk = ~clk;

  stream_pack #(.WIDTH(W), .RATIO(R), .TIMEOUT(T)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_cg    (cg),
    .i_data  (din),
    .i_valid (vld),
    .o_ready (ordy),
    .i_flush (fl),
    .o_data  (odata),
    .o_strb  (ostrb),
    .o_valid (oval),
    .i_ready (rdy),
    .o_count (ocnt)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  bit         mhold = 1'b0;
  int         mtmo  = 0;

  function automatic logic exp_ready();
    return cg && (!mhold || rdy);
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] d;
    d = '0;
    foreach (mq[i]) d[i*8 +: 8] = mq[i];
    return d;
  endfunction

  function automatic logic [3:0] exp_strb();
    return 4'((1 << mq.size()) - 1);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic f,
                       input logic r, input logic g, input logic x);
    vld = v; din = d; fl = f; rdy = r; cg = g; rst = x;
    #1;
  endtask

  task automatic tick();
    bit tin, tout, wfill, fire;
    tin   = vld && exp_ready();
    tout  = mhold && rdy && cg;
    wfill = !mhold && mq.size() > 0;
    fire  = TMO && wfill && !tin && (mtmo == T - 1);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mhold = 1'b0;
      mtmo  = 0;
    end else if (cg) begin
      if (mhold) begin
        if (tout) begin
          mq.delete();
          mhold = 1'b0;
          if (tin) begin
            mq.push_back(din);
            mhold = fl;
          end
        end
      end else begin
        if (tin) mq.push_back(din);
        if (mq.size() == R || (mq.size() > 0 && (fl || fire))) mhold = 1'b1;
      end
      mtmo = (wfill && !tin && !mhold) ? mtmo + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    drive(1, d, 0, 1, 1, 0);
    tick();
  endtask

  task automatic drain();
    drive(0, 0, 1, 1, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 1, 1);
    tick();
    tick();
    drive(0, 0, 0, 0, 1, 0);
    total++; if (oval !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", oval); end
    total++; if (ocnt !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", ocnt); end
    total++; if (odata !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", odata); end
    total++; if (ostrb !== 4'h0) begin bad++; $display("FAIL rst_strb got=%b exp=0000", ostrb); end
    total++; if (ordy !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", ordy); end
    drive(0, 0, 0, 0, 0, 0);
    total++; if (ordy !== 1'b0) begin bad++; $display("FAIL rst_ready_cg0 got=%0b exp=0", ordy); end
  endtask

  task automatic test_full();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    drive(0, 0, 0, 1, 1, 0);
    total++; if (oval !== 1'b1) begin bad++; $display("FAIL full_valid got=%0b exp=1", oval); end
    total++; if (odata !== 32'h44332211) begin bad++; $display("FAIL full_data got=%h exp=44332211", odata); end
    total++; if (ostrb !== 4'b1111) begin bad++; $display("FAIL full_strb got=%b exp=1111", ostrb); end
    total++; if (ocnt !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", ocnt); end
    tick();
    total++; if (oval !== 1'b0) begin bad++; $display("FAIL full_valid_drop got=%0b exp=0", oval); end
    total++; if (odata !== 32'h0) begin bad++; $display("FAIL full_clear got=%h exp=0", odata); end
  endtask

  task automatic test_flush();
    push(8'hAA); push(8'hBB);
    drive(0, 0, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    total++; if (oval !== 1'b1) begin bad++; $display("FAIL flush_valid got=%0b exp=1", oval); end
    total++; if (odata !== 32'h0000BBAA) begin bad++; $display("FAIL flush_data got=%h exp=0000bbaa", odata); end
    total++; if (ostrb !== 4'b0011) begin bad++; $display("FAIL flush_strb got=%b exp=0011", ostrb); end
    total++; if (ocnt !== 3'd2) begin bad++; $display("FAIL flush_count got=%0d exp=2", ocnt); end
    drive(0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 1, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    total++; if (oval !== 1'b0) begin bad++; $display("FAIL flush_idle_valid got=%0b exp=0", oval); end
    total++; if (ocnt !== 3'd0) begin bad++; $display("FAIL flush_idle_count got=%0d exp=0", ocnt); end
  endtask

  task automatic test_hold();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h99, 0, 0, 1, 0);
      total++; if (ordy !== 1'b0) begin bad++; $display("FAIL hold_ready c=%0d got=%0b exp=0", i, ordy); end
      total++; if (odata !== 32'hA4A3A2A1) begin bad++; $display("FAIL hold_data c=%0d got=%h exp=a4a3a2a1", i, odata); end
      total++; if (oval !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%0b exp=1", i, oval); end
      tick();
    end
    drive(1, 8'h55, 0, 1, 1, 0);
    total++; if (ordy !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%0b exp=1", ordy); end
    tick();
    drive(0, 0, 0, 1, 1, 0);
    total++; if (oval !== 1'b0) begin bad++; $display("FAIL hold_next_valid got=%0b exp=0", oval); end
    total++; if (ocnt !== 3'd1) begin bad++; $display("FAIL hold_next_count got=%0d exp=1", ocnt); end
    total++; if (odata !== 32'h00000055) begin bad++; $display("FAIL hold_next_data got=%h exp=00000055", odata); end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 0, 1, 1, 0);
      total++; if (ordy !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%0b exp=1", i, ordy); end
      tick();
      if (i == 4) begin
        total++; if (oval !== 1'b1 || odata !== 32'h04030201) begin bad++; $display("FAIL b2b_pkt0 got=%0b/%h exp=1/04030201", oval, odata); end
      end
      if (i == 8) begin
        total++; if (oval !== 1'b1 || odata !== 32'h08070605) begin bad++; $display("FAIL b2b_pkt1 got=%0b/%h exp=1/08070605", oval, odata); end
      end
    end
    drive(0, 0, 0, 1, 1, 0);
    tick();
  endtask

  task automatic test_timeout();
    push(8'h01);
`ifdef STREAM_PACK_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      tick();
      if (k < 4) begin
        total++; if (oval !== 1'b0) begin bad++; $display("FAIL tmo_early k=%0d got=%0b exp=0", k, oval); end
      end else begin
        total++; if (oval !== 1'b1) begin bad++; $display("FAIL tmo_valid got=%0b exp=1", oval); end
        total++; if (ostrb !== 4'b0001) begin bad++; $display("FAIL tmo_strb got=%b exp=0001", ostrb); end
      end
    end
`else
    for (int k = 0; k < 100; k++) begin
      drive(0, 0, 0, 0, 1, 0);
      tick();
      total++; if (oval !== 1'b0 || ocnt !== 3'd1) begin bad++; $display("FAIL notmo k=%0d got=%0b/%0d exp=0/1", k, oval, ocnt); end
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    push(8'h61); push(8'h62); push(8'h63);
    drive(0, 0, 0, 1, 1, 1);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    total++; if (ocnt !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", ocnt); end
    total++; if (oval !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", oval); end
    push(8'h77);
    drive(0, 0, 0, 1, 1, 0);
    total++; if (odata !== 32'h00000077) begin bad++; $display("FAIL rmid_lane0 got=%h exp=00000077", odata); end
    total++; if (ocnt !== 3'd1) begin bad++; $display("FAIL rmid_count1 got=%0d exp=1", ocnt); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive($urandom % 4 != 0, 8'($urandom), $urandom % 8 == 0,
            $urandom % 3 != 0, $urandom % 6 != 0, $urandom % 64 == 0);
      total++; if (oval !== mhold) begin bad++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, oval, mhold); end
      total++; if (ocnt !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, ocnt, mq.size()); end
      total++; if (odata !== exp_data()) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, odata, exp_data()); end
      total++; if (ordy !== exp_ready()) begin bad++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, ordy, exp_ready()); end
      if (mhold) begin
        total++; if (ostrb !== exp_strb()) begin bad++; $display("FAIL rnd_strb i=%0d got=%b exp=%b", i, ostrb, exp_strb()); end
      end
      tick();
    end
  endtask

  initial begin
    vld = 0; din = 0; fl = 0; rdy = 0; cg = 1; rst = 1;
    @(negedge clk);
    test_reset();
    test_full();
    test_flush();
    test_hold();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
